burst_mem_slave: RTL and testbench

Parametrised successor to the fixed 8×4 burst slave. It is a single-ported register-file memory behind separate read and write channels with valid/ready handshakes. Each burst carries its own start address and length, addressing wraps at DEPTH, read data carries a last-beat marker, and writes return a response code. It sits on the master/slave test fabric as the addressable memory endpoint.

---
 rtl/burst_mem_slave.sv | 192 +++++++++++++++++++
 tb/tb_burst_mem_slave.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_mem_slave.sv
// burst_mem_slave
//   Register-file memory endpoint with independent read and write channels.
//   Each burst supplies its own start address and length (beats = len + 1);
//   addressing wraps at DEPTH. Reads return data with a last-beat marker,
//   writes return a response: OKAY, or SLVERR if the master's w_last did not
//   line up with the burst length announced on aw_len. Reads win over writes
//   when both address channels are valid in the same idle cycle.
//
//   Despite its name, rst_n is an active-high synchronous reset: a 1 sampled
//   at a rising clk edge returns the block to IDLE and zeroes the memory, and
//   every output is held at 0 for as long as rst_n is 1.
//
// Ports
//   clk                        rising-edge clock
//   rst_n                      synchronous reset, active high
//   ar_valid/ar_ready          read address handshake
//   ar_addr [ADDR_W], ar_len   read start address, beats minus one
//   r_valid/r_ready            read data handshake
//   r_data [DATA_W], r_last    read data, final-beat marker
//   aw_valid/aw_ready          write address handshake
//   aw_addr [ADDR_W], aw_len   write start address, beats minus one
//   w_valid/w_ready            write data handshake
//   w_data [DATA_W], w_last    write data, master's final-beat marker
//   b_valid/b_ready            write response handshake
//   b_resp [2]                 2'b00 OKAY, 2'b10 SLVERR
module burst_mem_slave #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4,
    parameter int LEN_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ar_valid,
    output logic              ar_ready,
    input  logic [ADDR_W-1:0] ar_addr,
    input  logic [LEN_W-1:0]  ar_len,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [DATA_W-1:0] r_data,
    output logic              r_last,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic [LEN_W-1:0]  aw_len,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_last,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [1:0]        b_resp
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len;
    logic              err;
    logic [DATA_W-1:0] mem [DEPTH];

    logic last_beat;
    logic ar_hs;
    logic aw_hs;
    logic r_hs;
    logic w_hs;

    // Burst position is tracked by cnt against the latched length, so the
    // final beat is known regardless of where ptr has wrapped to.
    assign last_beat = (cnt == len);

    assign ar_hs = ar_valid && ar_ready;
    assign aw_hs = aw_valid && aw_ready;
    assign r_hs  = r_valid  && r_ready;
    assign w_hs  = w_valid  && w_ready;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; = here would let one flop see another's new value.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: memory words are cleared on reset because an aborted burst must
    // leave all-zero contents behind; this forces the array into flops.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            ptr <= '0;
            cnt <= '0;
            len <= '0;
            err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // Address handshakes only happen in IDLE and are mutually
            // exclusive (aw_ready drops whenever ar_valid is high).
            if (ar_hs) begin
                ptr <= ar_addr;
                len <= ar_len;
                cnt <= '0;
            end else if (aw_hs) begin
                ptr <= aw_addr;
                len <= aw_len;
                cnt <= '0;
                err <= 1'b0;
            end else if (r_hs || w_hs) begin
                ptr <= ptr + ADDR_W'(1);
                // cnt saturates at len; the burst ends on this beat anyway.
                if (!last_beat) begin
                    cnt <= cnt + LEN_W'(1);
                end
            end

            // Data is always stored; a misplaced w_last only poisons b_resp.
            if (w_hs) begin
                mem[ptr] <= w_data;
                if (w_last != last_beat) begin
                    err <= 1'b1;
                end
            end
        end
    end

    // NOTE: every output and state_next gets a default before the case so
    // no path through this block leaves a value unassigned (no latches).
    always_comb begin
        state_next = state;
        ar_ready   = 1'b0;
        aw_ready   = 1'b0;
        r_valid    = 1'b0;
        r_data     = '0;
        r_last     = 1'b0;
        w_ready    = 1'b0;
        b_valid    = 1'b0;
        b_resp     = RESP_OKAY;

        // While reset is asserted all outputs stay at their zero defaults.
        if (!rst_n) begin
            unique case (state)
                IDLE: begin
                    ar_ready = 1'b1;
                    aw_ready = !ar_valid;
                    if (ar_valid) begin
                        state_next = READ;
                    end else if (aw_valid) begin
                        state_next = WRITE;
                    end
                end
                READ: begin
                    r_valid = 1'b1;
                    r_data  = mem[ptr];
                    r_last  = last_beat;
                    if (r_ready && last_beat) begin
                        state_next = IDLE;
                    end
                end
                WRITE: begin
                    w_ready = 1'b1;
                    // Burst length comes from aw_len, not from w_last.
                    if (w_valid && last_beat) begin
                        state_next = RESP;
                    end
                end
                RESP: begin
                    b_valid = 1'b1;
                    b_resp  = err ? RESP_SLVERR : RESP_OKAY;
                    if (b_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_mem_slave.sv
// Self-checking bench for burst_mem_slave (default parameters).
// The reference model is a plain array of memory words updated per
// transaction; expected read data, r_last and b_resp are computed from the
// burst's start address, length and the beat index.
module tb_burst_mem_slave;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 4;
    localparam int LEN_W  = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic [LEN_W-1:0]  ar_len;
    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic              aw_valid;
    logic              aw_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic [LEN_W-1:0]  aw_len;
    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;
    logic              w_last;
    logic              b_valid;
    logic              b_ready;
    logic [1:0]        b_resp;

    burst_mem_slave #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ar_valid(ar_valid),
        .ar_ready(ar_ready),
        .ar_addr (ar_addr),
        .ar_len  (ar_len),
        .r_valid (r_valid),
        .r_ready (r_ready),
        .r_data  (r_data),
        .r_last  (r_last),
        .aw_valid(aw_valid),
        .aw_ready(aw_ready),
        .aw_addr (aw_addr),
        .aw_len  (aw_len),
        .w_valid (w_valid),
        .w_ready (w_ready),
        .w_data  (w_data),
        .w_last  (w_last),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_resp  (b_resp)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];

    typedef struct {
        logic rst;
        logic arv;
        logic awv;
        logic exp_ar_ready;
        logic exp_aw_ready;
    } idle_vec_t;

    idle_vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge: advance to just after the next one.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = '0;
        end
    endtask

    function automatic logic [8:0] all_outputs();
        return {ar_ready, aw_ready, r_valid, r_last, w_ready, b_valid, b_resp[1], b_resp[0],
                |r_data};
    endfunction

    // Read burst. r_ready is held low for hold_cycles cycles when beat
    // hold_after is due, otherwise it is randomly withheld stall_pct % of
    // the time. With hold_aw set, aw_valid is raised alongside ar_valid and
    // kept up for the whole read.
    task automatic do_read(input int addr, input int len, input int stall_pct,
                           input int hold_after, input int hold_cycles, input bit hold_aw);
        int beat;
        int held;
        int cyc;
        ar_valid = 1'b1;
        ar_addr  = ADDR_W'(addr);
        ar_len   = LEN_W'(len);
        r_ready  = 1'b0;
        if (hold_aw) aw_valid = 1'b1;
        #1;
        check("ar_ready_idle", ar_ready, 1);
        if (hold_aw) check("aw_ready_blocked_by_ar", aw_ready, 0);
        next_cycle();
        ar_valid = 1'b0;
        beat = 0;
        held = 0;
        cyc  = 0;
        while (beat <= len && cyc < 400) begin
            if (beat == hold_after && held < hold_cycles) begin
                r_ready = 1'b0;
                held++;
            end else begin
                r_ready = ($urandom_range(99) >= stall_pct);
            end
            #1;
            check("r_valid", r_valid, 1);
            check("r_data", r_data, model_mem[(addr + beat) % DEPTH]);
            check("r_last", r_last, (beat == len));
            check("ar_ready_busy", ar_ready, 0);
            if (hold_aw) check("aw_ready_busy", aw_ready, 0);
            if (r_ready) beat++;
            cyc++;
            next_cycle();
        end
        r_ready = 1'b0;
    endtask

    // Write burst of len+1 beats; w_last is driven on beat last_idx.
    task automatic do_write(input int addr, input int len, input int last_idx,
                            input int stall_pct, input bit seq_data, input int resp_delay);
        int beat;
        int cyc;
        logic [DATA_W-1:0] d;
        logic [1:0] exp_resp;
        ar_valid = 1'b0;
        aw_valid = 1'b1;
        aw_addr  = ADDR_W'(addr);
        aw_len   = LEN_W'(len);
        #1;
        check("aw_ready_idle", aw_ready, 1);
        next_cycle();
        aw_valid = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat <= len && cyc < 400) begin
            w_valid = ($urandom_range(99) >= stall_pct);
            d       = seq_data ? DATA_W'(beat + 1) : DATA_W'($urandom);
            w_data  = d;
            w_last  = (beat == last_idx);
            #1;
            check("w_ready", w_ready, 1);
            check("b_valid_during_write", b_valid, 0);
            check("aw_ready_busy", aw_ready, 0);
            if (w_valid) begin
                model_mem[(addr + beat) % DEPTH] = d;
                beat++;
            end
            cyc++;
            next_cycle();
        end
        w_valid  = 1'b0;
        w_last   = 1'b0;
        exp_resp = (last_idx == len) ? 2'b00 : 2'b10;
        for (int i = 0; i <= resp_delay; i++) begin
            b_ready = (i == resp_delay);
            #1;
            check("b_valid", b_valid, 1);
            check("b_resp", b_resp, exp_resp);
            check("w_ready_in_resp", w_ready, 0);
            next_cycle();
        end
        b_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{rst: 1'b0, arv: 1'b0, awv: 1'b0, exp_ar_ready: 1'b1, exp_aw_ready: 1'b1};
        vecs[1] = '{rst: 1'b0, arv: 1'b1, awv: 1'b0, exp_ar_ready: 1'b1, exp_aw_ready: 1'b0};
        vecs[2] = '{rst: 1'b0, arv: 1'b0, awv: 1'b1, exp_ar_ready: 1'b1, exp_aw_ready: 1'b1};
        vecs[3] = '{rst: 1'b0, arv: 1'b1, awv: 1'b1, exp_ar_ready: 1'b1, exp_aw_ready: 1'b0};
        vecs[4] = '{rst: 1'b1, arv: 1'b1, awv: 1'b1, exp_ar_ready: 1'b0, exp_aw_ready: 1'b0};

        rst_n    = 1'b1;
        ar_valid = 1'b1;
        ar_addr  = '0;
        ar_len   = '0;
        r_ready  = 1'b1;
        aw_valid = 1'b1;
        aw_addr  = '0;
        aw_len   = '0;
        w_valid  = 1'b1;
        w_data   = '1;
        w_last   = 1'b1;
        b_ready  = 1'b1;
        model_clear();

        // Reset held: every output is zero even with all inputs active.
        next_cycle();
        check("reset_outputs_zero", {23'd0, all_outputs()}, 32'd0);
        ar_valid = 1'b0;
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        w_last   = 1'b0;
        r_ready  = 1'b0;
        b_ready  = 1'b0;
        rst_n    = 1'b0;

        // Combinational IDLE decode, all applied between two clock edges.
        for (int i = 0; i < 5; i++) begin
            rst_n    = vecs[i].rst;
            ar_valid = vecs[i].arv;
            aw_valid = vecs[i].awv;
            #1;
            check($sformatf("idle_vec%0d_ar_ready", i), ar_ready, vecs[i].exp_ar_ready);
            check($sformatf("idle_vec%0d_aw_ready", i), aw_ready, vecs[i].exp_aw_ready);
            check($sformatf("idle_vec%0d_r_valid", i), r_valid, 0);
        end
        rst_n    = 1'b0;
        ar_valid = 1'b0;
        aw_valid = 1'b0;
        next_cycle();

        // Full read of freshly reset memory.
        do_read(0, 7, 0, -1, 0, 1'b0);

        // Write 1..4 from address 5 (wraps to 0), then read it back.
        do_write(5, 3, 3, 0, 1'b1, 0);
        do_read(5, 3, 0, -1, 0, 1'b0);

        // Simultaneous ar/aw: read wins, write taken in the first IDLE cycle.
        do_read(1, 2, 0, -1, 0, 1'b1);
        do_write(3, 1, 1, 0, 1'b0, 0);

        // Backpressure: r_ready low for 3 cycles when beat 2 is due.
        do_read(5, 3, 0, 2, 3, 1'b0);

        // Early w_last: all beats written, SLVERR; next clean burst is OKAY.
        do_write(2, 3, 1, 0, 1'b0, 2);
        do_write(6, 2, 2, 0, 1'b0, 1);
        do_read(0, 7, 0, -1, 0, 1'b0);

        // Reset two beats into a write burst.
        aw_valid = 1'b1;
        aw_addr  = 3'd2;
        aw_len   = 3'd5;
        next_cycle();
        aw_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w_valid = 1'b1;
            w_data  = DATA_W'(4'hA + i);
            w_last  = 1'b0;
            next_cycle();
        end
        rst_n    = 1'b1;
        ar_valid = 1'b1;
        #1;
        check("midburst_reset_outputs_zero", {23'd0, all_outputs()}, 32'd0);
        next_cycle();
        rst_n    = 1'b0;
        ar_valid = 1'b0;
        w_valid  = 1'b0;
        model_clear();
        #1;
        check("after_reset_w_ready", w_ready, 0);
        check("after_reset_b_valid", b_valid, 0);
        do_read(0, 7, 0, -1, 0, 1'b0);

        // Randomised traffic against the model.
        for (int t = 0; t < 40; t++) begin
            int a;
            int l;
            a = $urandom_range(DEPTH - 1);
            l = $urandom_range((1 << LEN_W) - 1);
            if ($urandom_range(1) == 1) begin
                do_read(a, l, 30, -1, 0, 1'b0);
            end else begin
                int li;
                li = ($urandom_range(3) == 0) ? $urandom_range(7) : l;
                do_write(a, l, li, 30, 1'b0, $urandom_range(2));
            end
        end
        do_read(0, 7, 0, -1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
